mux_scan_ctrl: RTL
==================

Name: mux_scan_ctrl

Overview:
- Upstream sequencer for the 16:1 bit-select mux.
- Accepts a parallel word over a valid/ready load port, holds it on the mux data inputs, and steps the mux select through every index.
- Returns each selected bit from the mux output as a serial valid/ready stream, flags the last bit, and pulses done after the final bit is taken.

Parameters:
SEL_W, 4, select width; word width N = 2**SEL_W (16 at default, matching the mux).
MSB_FIRST, 0, 0 = index 0 first, counting up; 1 = index N-1 first, counting down.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous reset, active-high.
load_valid  input  1  load_data is valid.
load_ready  output  1  block can accept a word (IDLE state only).
load_data  input  N  parallel word to serialize.
mux_in  output  N  held data register; drives the mux in[] bus.
mux_sel  output  SEL_W  registered select index; drives the mux sel input.
mux_out  input  1  mux output (in[sel]), returned combinationally.
ser_valid  output  1  ser_bit is valid.
ser_ready  input  1  downstream accepts the bit.
ser_bit  output  1  serial data, equal to mux_out.
ser_last  output  1  current bit is the final index.
done  output  1  one-cycle pulse after the final bit is accepted.

Behaviour:
- All state updates on the rising clk edge. rst is sampled only at that edge and overrides every other input.
- Reset values:
  - state = IDLE, data register = 0, mux_sel = start index (0, or N-1 when MSB_FIRST=1).
  - ser_valid = 0, ser_last = 0, done = 0.
  - load_ready = 0 while rst is high, and 1 from the first cycle after rst falls.
- States: IDLE and SHIFT.
- IDLE:
  - load_ready = 1, ser_valid = 0.
  - On load_valid & load_ready: data register <= load_data, mux_sel <= start index, next state SHIFT.
  - Otherwise hold state.
- SHIFT:
  - load_ready = 0, ser_valid = 1.
  - ser_bit = mux_out, combinational pass-through with no added latency. The data register and mux_sel are stable for the whole cycle.
  - ser_last = 1 when mux_sel equals the end index (N-1, or 0 when MSB_FIRST=1).
  - Accept means ser_valid & ser_ready.
  - Accept on a non-last index: mux_sel steps by ±1 on the next edge.
  - Accept on the last index: next state IDLE, done = 1 for exactly the following cycle, mux_sel returns to the start index.
  - No accept (stall): mux_sel, the data register and ser_bit hold indefinitely.
- Throughput: one bit per cycle with ser_ready held high. A word occupies N SHIFT cycles, plus 1 IDLE cycle before the next load can be accepted.
  - done and load_ready are both high in that IDLE cycle, so a load accepted there starts SHIFT on the next edge (N+1 cycles per word back-to-back).
- load_valid in SHIFT is ignored. The word is not captured, and the upstream source must hold it until load_ready.
- mux_sel arithmetic is SEL_W-bit and never wraps during a word, because termination happens at the end index.
- The data register changes only on load accept, so mux_in is stable for the whole word.
- Reset mid-word: the word is abandoned, with no done pulse and no further ser_valid. The block is in IDLE on the next cycle.
- The mux is combinational, so no extra cycle is inserted between mux_sel and ser_bit.

Test Plan:
1. Reset, then load 16'hA5C3 with MSB_FIRST=0 and ser_ready=1 → ser_bit sequence, index 0 to 15, is 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1. ser_last is high only on the 16th bit. done pulses once, the cycle after. load_ready returns to 1.
2. MSB_FIRST=1, load 16'h8001 → mux_sel runs 15 down to 0. Bits are 1, fourteen 0s, then 1. ser_last is high at mux_sel=0.
3. Load 16'hFFFF, hold ser_ready=0 for 5 cycles at index 3, then raise it → mux_sel stays 3 and ser_valid stays 1 through the stall. Total bits accepted = 16 and done pulses once.
4. Back-to-back loads 16'h1234 then 16'hFFFF, load_valid held high → the second word is accepted in the done cycle. The first bit of word 2 appears N+1 cycles after the first bit of word 1. Pulsing load_valid with 16'h0000 during SHIFT changes nothing.
5. Assert rst at index 7 of 16'h5555 → the next cycle has ser_valid=0, done=0 and mux_sel=0. load_ready=1 after rst falls, and a fresh load serializes correctly.
6. Random words and random ser_ready over 200 words against a reference model → every serial stream equals the loaded word in the configured bit order.

Source files
------------

// File: rtl/mux_scan_if.sv
// -----------------------------------------------------------------------------
// mux_scan_if
//   Bundle of signals between mux_scan_ctrl, the 16:1 bit-select mux and the
//   load/serial endpoints.
//
//   load_valid / load_ready / load_data : parallel word load handshake
//   mux_in / mux_sel                    : held word and select index to the mux
//   mux_out                             : selected bit returned by the mux
//   ser_valid / ser_ready / ser_bit     : serial bit stream handshake
//   ser_last                            : current serial bit is the final index
//   done                                : one-cycle pulse after the final bit
//
//   master : the sequencer side (mux_scan_ctrl)
//   slave  : the surrounding environment (loader, mux, serial consumer)
// -----------------------------------------------------------------------------
interface mux_scan_if #(
   parameter int SEL_W = 4
);
   localparam int N = 2 ** SEL_W;

   logic             load_valid;
   logic             load_ready;
   logic [N-1:0]     load_data;
   logic [N-1:0]     mux_in;
   logic [SEL_W-1:0] mux_sel;
   logic             mux_out;
   logic             ser_valid;
   logic             ser_ready;
   logic             ser_bit;
   logic             ser_last;
   logic             done;

   modport master (
      input  load_valid, load_data, mux_out, ser_ready,
      output load_ready, mux_in, mux_sel, ser_valid, ser_bit, ser_last, done
   );

   modport slave (
      output load_valid, load_data, mux_out, ser_ready,
      input  load_ready, mux_in, mux_sel, ser_valid, ser_bit, ser_last, done
   );
endinterface

// File: rtl/mux_scan_ctrl.sv
// -----------------------------------------------------------------------------
// mux_scan_ctrl
//   Upstream sequencer for a 2**SEL_W : 1 bit-select mux. A parallel word is
//   taken over the load handshake and held on the mux data inputs; the select
//   is then stepped through every index and each selected bit is handed out
//   as a serial valid/ready stream. ser_last marks the final index and done
//   pulses for one cycle after that bit is accepted.
//
//   Parameters
//     SEL_W     : select width, word width N = 2**SEL_W
//     MSB_FIRST : 0 = index 0 first counting up, 1 = index N-1 first counting down
//
//   Ports
//     clk : rising-edge clock
//     rst : synchronous reset, active-high
//     bus : mux_scan_if.master (load port, mux drive/return, serial port, done)
// -----------------------------------------------------------------------------
module mux_scan_ctrl #(
   parameter int SEL_W     = 4,
   parameter int MSB_FIRST = 0
) (
   input  logic          clk,
   input  logic          rst,
   mux_scan_if.master    bus
);

   localparam int N = 2 ** SEL_W;

   localparam logic [SEL_W-1:0] ALL_ONES  = {SEL_W{1'b1}};
   localparam logic [SEL_W-1:0] START_IDX = (MSB_FIRST != 0) ? ALL_ONES : '0;
   localparam logic [SEL_W-1:0] END_IDX   = (MSB_FIRST != 0) ? '0 : ALL_ONES;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_nxt;
   logic [N-1:0]     data_q, data_nxt;
   logic [SEL_W-1:0] sel_q, sel_nxt;
   logic             done_q, done_nxt;

   logic             load_ready_c;
   logic             ser_valid_c;
   logic             ser_last_c;
   logic             at_end;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of every other flop, regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         data_q  <= '0;
         sel_q   <= START_IDX;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_nxt;
         data_q  <= data_nxt;
         sel_q   <= sel_nxt;
         done_q  <= done_nxt;
      end
   end

   assign at_end = (sel_q == END_IDX);

   // NOTE: every output of this block is given a default before the case so
   // no path leaves a signal unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt    = state_q;
      data_nxt     = data_q;
      sel_nxt      = sel_q;
      done_nxt     = 1'b0;
      load_ready_c = 1'b0;
      ser_valid_c  = 1'b0;
      ser_last_c   = 1'b0;

      case (state_q)
         IDLE: begin
            // Held low while rst is asserted so no load is offered during reset.
            load_ready_c = !rst;
            if (bus.load_valid && load_ready_c) begin
               data_nxt  = bus.load_data;
               sel_nxt   = START_IDX;
               state_nxt = SHIFT;
            end
         end

         SHIFT: begin
            ser_valid_c = 1'b1;
            ser_last_c  = at_end;
            if (bus.ser_ready) begin
               if (at_end) begin
                  // Termination at the end index means the select never wraps.
                  state_nxt = IDLE;
                  sel_nxt   = START_IDX;
                  done_nxt  = 1'b1;
               end else if (MSB_FIRST != 0) begin
                  sel_nxt = sel_q - 1'b1;
               end else begin
                  sel_nxt = sel_q + 1'b1;
               end
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign bus.load_ready = load_ready_c;
   assign bus.mux_in     = data_q;
   assign bus.mux_sel    = sel_q;
   assign bus.ser_valid  = ser_valid_c;
   assign bus.ser_last   = ser_last_c;
   // The mux is combinational, so its output is the serial bit with no added latency.
   assign bus.ser_bit    = bus.mux_out;
   assign bus.done       = done_q;

endmodule
